// File: rtl/interval_arbiter.sv
// Two-requester arbiter that lends one WIDTH-bit interval counter to a single owner at a time.
// Build option: define ROUND_ROBIN_EN for last-served tie-breaking; otherwise requester 0 wins ties.
module interval_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [1:0]       req_i,
   input  logic [WIDTH-1:0] dur0_i,
   input  logic [WIDTH-1:0] dur1_i,
   output logic [1:0]       grant_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] count_o,
   output logic [1:0]       done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [1:0]       done_q, done_d;
   logic [WIDTH-1:0] dur_q, dur_d;
   logic             win_s;
   logic             own_s;

   // The current owner is implied by which grant bit is set.
   assign own_s = grant_q[1];

`ifdef ROUND_ROBIN_EN
   logic last_q, last_d;

   // Tie goes to whoever was not served last; a lone request simply wins.
   always_comb begin
      win_s = 1'b0;
      if (req_i == 2'b11) begin
         win_s = ~last_q;
      end else begin
         win_s = req_i[1];
      end
   end
`else
   // Fixed priority: requester 1 only wins when it asks alone.
   always_comb begin
      win_s = 1'b0;
      if (req_i == 2'b10) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end
`endif

   // Next-state and next-output logic for the grant / run / done sequence.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      count_d = count_q;
      done_d  = 2'b00;
      dur_d   = dur_q;
`ifdef ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            grant_d = 2'b00;
            count_d = '0;
            if (req_i != 2'b00) begin
               state_d = S_RUN;
               grant_d = win_s ? 2'b10 : 2'b01;
               dur_d   = win_s ? dur1_i : dur0_i;
`ifdef ROUND_ROBIN_EN
               last_d  = win_s;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (!req_i[own_s]) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
               count_d = '0;
            end else if (count_q == dur_q) begin
               state_d = S_DONE;
               done_d  = grant_q;
            end else begin
               count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            // Requests are deliberately not looked at here; the interval is already complete.
            state_d = S_IDLE;
            grant_d = 2'b00;
            count_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            count_d = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         grant_q <= 2'b00;
         busy_q  <= 1'b0;
         count_q <= '0;
         done_q  <= 2'b00;
         dur_q   <= '0;
`ifdef ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         done_q  <= done_d;
         dur_q   <= dur_d;
`ifdef ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = busy_q;
   assign count_o = count_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// Randomized and directed bench for interval_arbiter against a cycle-level behavioural model.
module tb_interval_arbiter;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req;
   logic [WIDTH-1:0] dur0, dur1;
   logic [1:0]       grant;
   logic             busy;
   logic [WIDTH-1:0] count;
   logic [1:0]       done;

   int n_vec = 0;
   int n_err = 0;

   // Model: owner is -1 when idle; phase 0 idle, 1 counting, 2 completion cycle.
   int m_phase, m_owner, m_cnt, m_dur, m_last;

   interval_arbiter #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .req_i   (req),
      .dur0_i  (dur0),
      .dur1_i  (dur1),
      .grant_o (grant),
      .busy_o  (busy),
      .count_o (count),
      .done_o  (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int pick_winner(input logic [1:0] r);
      if (r == 2'b11) begin
`ifdef ROUND_ROBIN_EN
         return (m_last == 0) ? 1 : 0;
`else
         return 0;
`endif
      end
      return (r == 2'b10) ? 1 : 0;
   endfunction

   task automatic model_step();
      if (reset) begin
         m_phase = 0; m_owner = -1; m_cnt = 0; m_dur = 0; m_last = 1;
      end else if (m_phase == 0) begin
         m_cnt = 0;
         if (req != 2'b00) begin
            m_owner = pick_winner(req);
            m_last  = m_owner;
            m_dur   = (m_owner == 1) ? int'(dur1) : int'(dur0);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!req[m_owner]) begin
            m_phase = 0; m_owner = -1; m_cnt = 0;
         end else if (m_cnt == m_dur) begin
            m_phase = 2;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end else begin
         m_phase = 0; m_owner = -1; m_cnt = 0;
      end
   endtask

   function automatic logic [1:0] exp_grant();
      return (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
   endfunction

   function automatic logic [1:0] exp_done();
      return (m_phase == 2) ? exp_grant() : 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_eq("grant", {30'd0, grant}, {30'd0, exp_grant()});
      check_eq("busy",  {31'd0, busy},  {31'd0, (m_phase != 0)});
      check_eq("count", {28'd0, count}, m_cnt);
      check_eq("done",  {30'd0, done},  {30'd0, exp_done()});
      // Requesters honour the contract and release once they see completion.
      if (m_phase == 2) req[m_owner] = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int own_cycles;
   int guard;

   initial begin
      reset = 1'b1; req = 2'b00; dur0 = '0; dur1 = '0;
      run(2);
      reset = 1'b0;
      check_eq("rst_grant", {30'd0, grant}, 32'd0);
      check_eq("rst_count", {28'd0, count}, 32'd0);

      // Single request, duration 3.
      dur0 = 4'd3; req = 2'b01;
      run(8);

      // Both request together, duration 2 each.
      dur0 = 4'd2; dur1 = 4'd2; req = 2'b11;
      run(14);

      // Zero-length interval on requester 1.
      dur1 = 4'd0; req = 2'b10;
      tick();
      check_eq("d0_grant", {30'd0, grant}, 32'd2);
      dur1 = 4'd7;
      run(4);

      // Abort at count 4.
      dur0 = 4'd9; req = 2'b01;
      guard = 0;
      while (!(m_phase == 1 && m_cnt == 4) && guard < 20) begin tick(); guard++; end
      check_eq("abort_reach", guard < 20, 1);
      req = 2'b00;
      tick();
      check_eq("abort_grant", {30'd0, grant}, 32'd0);
      run(3);

      // Synchronous reset while counting, then a tie resolves to requester 0.
      dur0 = 4'd9; req = 2'b01;
      guard = 0;
      while (!(m_phase == 1 && m_cnt == 2) && guard < 20) begin tick(); guard++; end
      check_eq("rst_reach", guard < 20, 1);
      reset = 1'b1;
      tick();
      check_eq("midrst_done", {30'd0, done}, 32'd0);
      reset = 1'b0; req = 2'b11; dur0 = 4'd1; dur1 = 4'd1;
      tick();
      check_eq("post_rst_tie", {30'd0, grant}, 32'd1);
      run(12);

      // Maximum duration: ownership spans 17 cycles with no wrap.
      req = 2'b00; run(2);
      dur0 = 4'd15; req = 2'b01;
      own_cycles = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (grant != 2'b00) own_cycles++;
      end
      check_eq("own_17", own_cycles, 17);

      // Randomized traffic with occasional aborts and resets.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req[i] && ($urandom % 4) == 0) req[i] = 1'b1;
            else if (req[i] && ($urandom % 40) == 0) req[i] = 1'b0;
         end
         dur0  = WIDTH'($urandom);
         dur1  = WIDTH'($urandom);
         reset = (($urandom % 150) == 0);
         tick();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/interval_arbiter.md
# interval_arbiter

- Shares one WIDTH-bit up-counter timing resource between two requesters.
- Each requester asks for an interval of a given number of cycles. The block grants the counter to one requester at a time, runs the count, and signals completion to the winner.
- Sits between the counter datapath and the two agents that need timed intervals. The agents never drive the counter directly.

## Interface
Parameters:
- WIDTH, 4, counter and duration width in bits.

Ports:
- clk  input  1  system clock; the only clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  per-requester request level; bit i belongs to requester i.
- dur0  input  WIDTH  interval length requested by requester 0; sampled at grant.
- dur1  input  WIDTH  interval length requested by requester 1; sampled at grant.
- grant  output  2  one-hot (or zero) owner of the counter; registered.
- busy  output  1  high whenever state is not IDLE; registered.
- count  output  WIDTH  current counter value; registered.
- done  output  2  one-cycle completion pulse to the owning requester; registered.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset values: state IDLE, grant 0, busy 0, count 0, done 0, round-robin pointer "last served = 1", latched duration 0.
- IDLE:
  - If req == 0, stay in IDLE with count held at 0.
  - Otherwise pick a winner w, then on the next edge: grant[w]=1, busy=1, count=0, latch dur_w into an internal register D, go to RUN.
- Arbitration:
  - A single request wins.
  - If both requests are high, the requester not last served wins.
  - The pointer updates to w on every grant.
- RUN, each edge:
  - If req[w] is low (abort): next state IDLE, grant=0, busy=0, count=0, no done pulse.
  - Else if count == D: next state DONE, done[w]=1, count holds.
  - Else: count = count + 1. Arithmetic is modulo 2^WIDTH, but wrap is unreachable because count never exceeds D.
- DONE:
  - Lasts exactly one cycle. grant[w] stays high and done[w] is high.
  - Next edge: state IDLE, grant=0, done=0, busy=0, count=0.
  - req is ignored during DONE; a request abort is not checked in DONE.
- Requester contract: drop req after seeing done. A req still high in IDLE is a new request and is arbitrated normally.
- Changes to dur0/dur1 after grant have no effect on the running interval.
- D = 0 is legal: RUN lasts one cycle, with done on the following cycle.
- reset has priority over all transitions. Reset mid-RUN or mid-DONE terminates the interval with no done pulse, and all outputs return to reset values on that edge.

## Timing
- Request sampled high at edge k (state IDLE):
  - After edge k: grant and busy high, count=0.
  - After edge k+j, for j ≤ D: count=j.
  - After edge k+D+1: done high for one cycle.
  - After edge k+D+2: grant, busy and done are low and the block is in IDLE.
- Total ownership: D+2 cycles. Minimum idle gap between consecutive grants: 1 cycle (the IDLE cycle).
- Abort: req[w] sampled low at edge m during RUN gives grant=0 after edge m.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ROUND_ROBIN_EN defined: arbitration on simultaneous requests is round-robin via the last-served pointer, as described above.
- ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties, and the pointer logic is removed. All other behaviour is identical.

## Test plan
- Reset, then req=01, dur0=3: grant=01 one edge after the request; count runs 0,1,2,3; done=01 for exactly one cycle after count=3; grant=00 the next cycle.
- req=11 held with dur0=dur1=2, each requester dropping req one cycle after its done:
  - With ROUND_ROBIN_EN, grants go 01 then 10.
  - Without it, requester 0 wins first, and requester 1 is granted only after req0 drops.
- dur1=0, req=10: count stays 0, done=10 on the second cycle after grant, total grant width 2 cycles.
- Abort: dur0=9, drop req0 when count=4: grant=00 and count=0 on the next edge, done never pulses, busy=0.
- Synchronous reset asserted while count=2 in RUN: on that edge all outputs are 0 and no done pulse occurs. A subsequent req0 with ROUND_ROBIN_EN wins a tie, since the pointer was reset.
- WIDTH=4, dur0=15: count reaches 15 without wrap, done pulses, and total ownership is 17 cycles.
